round_sgf_pipe: RTL
===================

# round_sgf_pipe

Pipelined, parametrised significand rounding unit for the FPU datapath. It replaces the purely combinational sign/mode round-decision logic. It accepts an unrounded significand with guard and sticky bits, decides whether to round, and applies the increment. It returns the rounded significand, an exponent-increment carry and an inexact flag, two cycles later, behind a valid/ready handshake. Four modes are supported, adding round-to-nearest-even to the three directed modes. Instantiated between normalisation and exponent adjust in every arithmetic core.

## Interface
Parameters:
- W, 23 — width of the kept significand field (23 single, 52 double); W ≥ 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset; synchronous, active-high.
- In_Valid_i  in  1  input beat present.
- In_Ready_o  out  1  unit accepts a beat this cycle.
- Sgf_i  in  W+2  {kept[W-1:0], guard, sticky}.
- Round_Type_i  in  2  00 toward zero, 01 toward −inf, 10 toward +inf, 11 nearest-even.
- Sign_Result_i  in  1  sign of the result (1 = negative).
- Out_Valid_o  out  1  result beat present.
- Out_Ready_i  in  1  downstream accepts the result.
- Sgf_o  out  W  rounded kept significand.
- Carry_o  out  1  rounding overflowed the kept field; exponent must increment.
- Round_Flag_o  out  1  an increment was applied.
- Inexact_o  out  1  guard | sticky was nonzero.

## Operation
- Decision, with g = Sgf_i[1], s = Sgf_i[0], lsb = Sgf_i[2]:
  - mode 00 → flag 0.
  - mode 01 → flag = sign & (g|s).
  - mode 10 → flag = ~sign & (g|s).
  - mode 11 → flag = g & (s | lsb).
- Inexact = g | s, independent of mode.
- Increment: {Carry, Sgf} = {1'b0, kept} + flag, computed W+1 bits wide.
  - All-ones kept with flag 1 gives Sgf_o = 0 and Carry_o = 1.
- Stage 1 (S1) registers kept, flag, inexact and s1_valid.
- Stage 2 (S2) registers the increment result and s2_valid; Out_Valid_o = s2_valid.
- Stage advance rules:
  - S2 loads when ~s2_valid | Out_Ready_i.
  - S1 loads when ~s1_valid | S2 loads.
  - In_Ready_o = S1 load condition.
- A beat is accepted when In_Valid_i & In_Ready_o. A result is consumed when Out_Valid_o & Out_Ready_i.
- Hold rule: while Out_Valid_o & ~Out_Ready_i, all S2 outputs hold stable. S1 holds if also full.
- Bubbles: a stage with no valid beat arriving clears its valid bit. Its data registers may keep stale values, and outputs are don't-care while Out_Valid_o = 0.
- No internal state machine beyond the two valid bits. The pipeline states are: empty (00), S1 only, S2 only, full (11).

## Timing
- Latency: 2 cycles from acceptance edge to Out_Valid_o, with no backpressure.
- Throughput: 1 beat/cycle while Out_Ready_i = 1.
- In_Ready_o is combinational from Out_Ready_i and the valid bits. There is no combinational path from In_Valid_i or data to any output.
- Reset: the cycle after rst is sampled high, s1_valid = s2_valid = 0, and Sgf_o, Carry_o, Round_Flag_o, Inexact_o = 0.
  - In_Ready_o is 1 whenever rst is low and the pipe is empty.
  - rst mid-operation discards in-flight beats with no output.
- Full pipe with Out_Ready_i = 0: In_Ready_o = 0 and input is ignored.
- Full pipe with Out_Ready_i = 1: consume, shift and accept occur in the same cycle.
- Round_Type_i and Sign_Result_i are sampled only on acceptance. Later changes do not affect in-flight beats.

## Structure
- Shared package fpu_round_pkg holds:
  - localparams RND_ZERO = 2'b00, RND_NEG = 2'b01, RND_POS = 2'b10, RND_NEAR = 2'b11;
  - the packed result type {carry, flag, inexact}.
- One combinational sub-module, round_sgf_decide (inputs lsb, g, s, sign, mode; outputs flag, inexact), feeds S1. It is reused by other cores needing the decision only.
- The pipeline and handshake live in round_sgf_pipe; the W+1 adder sits in S2 input logic.

## Test plan
- W=4, mode 11: kept 0101, g=1, s=0 → Sgf_o 0110, flag 1, Carry_o 0, Inexact_o 1 (tie to even). Kept 0100, g=1, s=0 → 0100, flag 0.
- W=4, mode 10, sign 0: kept 1111, g=0, s=1 → Sgf_o 0000, Carry_o 1, flag 1, output valid exactly 2 cycles after acceptance.
- Modes 01/10 × sign 0/1 × (g,s) = 00/01/10/11: flag matches the directed rules. Mode 00 gives flag 0 with Inexact_o = g|s.
- Stream 8 beats with Out_Ready_i held 0 from cycle 3 for 4 cycles:
  - In_Ready_o drops after 2 beats are held;
  - outputs stay stable while held;
  - all 8 results emerge in order, with none lost or duplicated.
- Assert rst with 2 beats in flight → next cycle Out_Valid_o = 0, outputs 0, In_Ready_o = 1. The discarded beats never appear.
- Back-to-back beats with Out_Ready_i = 1: one result per cycle, with a 2-cycle offset.

Source files
------------

// File: rtl/fpu_round_pkg.sv
// rtl/fpu_round_pkg.sv - shared rounding mode encodings and packed rounding result type
package fpu_round_pkg;

    localparam logic [1:0] RND_ZERO = 2'b00;
    localparam logic [1:0] RND_NEG  = 2'b01;
    localparam logic [1:0] RND_POS  = 2'b10;
    localparam logic [1:0] RND_NEAR = 2'b11;

    typedef struct packed {
        logic carry;
        logic flag;
        logic inexact;
    } rnd_res_t;

endpackage

// File: rtl/round_sgf_pipe_if.sv
// rtl/round_sgf_pipe_if.sv - input/output beat bundle of the significand rounding pipe
interface round_sgf_pipe_if #(
    parameter int W = 23
);
    logic         In_Valid_i;
    logic         In_Ready_o;
    logic [W+1:0] Sgf_i;
    logic [1:0]   Round_Type_i;
    logic         Sign_Result_i;
    logic         Out_Valid_o;
    logic         Out_Ready_i;
    logic [W-1:0] Sgf_o;
    logic         Carry_o;
    logic         Round_Flag_o;
    logic         Inexact_o;

    modport master (
        output In_Valid_i, Sgf_i, Round_Type_i, Sign_Result_i, Out_Ready_i,
        input  In_Ready_o, Out_Valid_o, Sgf_o, Carry_o, Round_Flag_o, Inexact_o
    );

    modport slave (
        input  In_Valid_i, Sgf_i, Round_Type_i, Sign_Result_i, Out_Ready_i,
        output In_Ready_o, Out_Valid_o, Sgf_o, Carry_o, Round_Flag_o, Inexact_o
    );
endinterface

// File: rtl/round_sgf_decide.sv
// rtl/round_sgf_decide.sv - combinational round-up decision from lsb, guard, sticky, sign and mode
module round_sgf_decide
    import fpu_round_pkg::*;
(
    input  logic       lsb,
    input  logic       g,
    input  logic       s,
    input  logic       sign,
    input  logic [1:0] mode,
    output logic       flag,
    output logic       inexact
);

    always_comb begin
        flag    = 1'b0;
        inexact = g | s;
        case (mode)
            RND_ZERO: flag = 1'b0;
            RND_NEG:  flag = sign & (g | s);
            RND_POS:  flag = ~sign & (g | s);
            RND_NEAR: flag = g & (s | lsb);
            default:  flag = 1'b0;
        endcase
    end

endmodule

// File: rtl/round_sgf_pipe.sv
// rtl/round_sgf_pipe.sv - two-stage valid/ready significand rounding pipe (decide in S1, increment in S2)
module round_sgf_pipe
    import fpu_round_pkg::*;
#(
    parameter int W = 23
) (
    input  logic             clk,
    input  logic             rst,
    round_sgf_pipe_if.slave  io
);

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] s1_kept_q, s1_kept_d;
    logic         s1_flag_q, s1_flag_d;
    logic         s1_inexact_q, s1_inexact_d;
    logic         s2_valid_q, s2_valid_d;
    logic [W-1:0] s2_sgf_q, s2_sgf_d;
    rnd_res_t     s2_res_q, s2_res_d;

    logic         s2_load;
    logic         s1_load;
    logic         accept;
    logic         dec_flag;
    logic         dec_inexact;
    logic [W:0]   sum;

    round_sgf_decide u_decide (
        .lsb     (io.Sgf_i[2]),
        .g       (io.Sgf_i[1]),
        .s       (io.Sgf_i[0]),
        .sign    (io.Sign_Result_i),
        .mode    (io.Round_Type_i),
        .flag    (dec_flag),
        .inexact (dec_inexact)
    );

    // Each stage advances when its successor is empty or draining this cycle.
    always_comb begin
        s2_load = ~s2_valid_q | io.Out_Ready_i;
        s1_load = ~s1_valid_q | s2_load;
        accept  = io.In_Valid_i & s1_load;
        sum     = {1'b0, s1_kept_q} + {{W{1'b0}}, s1_flag_q};

        s1_valid_d   = s1_load ? io.In_Valid_i : s1_valid_q;
        s1_kept_d    = s1_kept_q;
        s1_flag_d    = s1_flag_q;
        s1_inexact_d = s1_inexact_q;
        if (accept) begin
            s1_kept_d    = io.Sgf_i[W+1:2];
            s1_flag_d    = dec_flag;
            s1_inexact_d = dec_inexact;
        end

        s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
        s2_sgf_d   = s2_sgf_q;
        s2_res_d   = s2_res_q;
        if (s2_load & s1_valid_q) begin
            s2_sgf_d         = sum[W-1:0];
            s2_res_d.carry   = sum[W];
            s2_res_d.flag    = s1_flag_q;
            s2_res_d.inexact = s1_inexact_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_kept_q    <= '0;
            s1_flag_q    <= 1'b0;
            s1_inexact_q <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sgf_q     <= '0;
            s2_res_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_kept_q    <= s1_kept_d;
            s1_flag_q    <= s1_flag_d;
            s1_inexact_q <= s1_inexact_d;
            s2_valid_q   <= s2_valid_d;
            s2_sgf_q     <= s2_sgf_d;
            s2_res_q     <= s2_res_d;
        end
    end

    assign io.In_Ready_o   = s1_load;
    assign io.Out_Valid_o  = s2_valid_q;
    assign io.Sgf_o        = s2_sgf_q;
    assign io.Carry_o      = s2_res_q.carry;
    assign io.Round_Flag_o = s2_res_q.flag;
    assign io.Inexact_o    = s2_res_q.inexact;

endmodule
